ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_pkg.sv | 15 +
 rtl/ifq_ptr.sv | 41 ++++
 rtl/ifetch_queue.sv | 129 ++++++++++++
 tb/tb_ifetch_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-side definitions: queue entry layout, default depth, PC width.
// Used by ifetch_queue and ifq_ptr.
package ifetch_queue_pkg;

  localparam int unsigned IFQ_DEPTH = 8;
  localparam int unsigned IFQ_PC_W  = 32;
  localparam int unsigned INSTR_W   = 32;

  // One queued fetch: instruction word plus its PC.
  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [IFQ_PC_W-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_ptr.sv
// Wrapping pointer register for a DEPTH-entry circular buffer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   inc       : advance by one, wrapping DEPTH-1 -> 0
//   clr       : force to 0 (has priority over inc)
//   ptr       : current pointer value
module ifq_ptr #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       clr,
  output logic [$clog2(DEPTH)-1:0]   ptr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_n;

  // Next pointer: clear wins, otherwise wrap explicitly at the last slot.
  always_comb begin
    ptr_n = ptr;
    if (clr) begin
      ptr_n = '0;
    end else if (inc) begin
      ptr_n = (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_n;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: circular buffer between fetch and decode.
// Optional same-cycle empty-queue bypass enabled by IFETCH_QUEUE_BYPASS_EN.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   enq_valid, enq_instr, enq_pc   : fetch side write
//   I_FIFO_Full                    : queue full (registered), feeds fetch stall
//   deq_ready                      : decode consumes the head
//   deq_valid, deq_instr, deq_pc   : head entry (data read straight from storage)
//   flush                          : discard everything (redirect/mispredict)
//   count                          : occupancy (registered)
// PC_W must not exceed IFQ_PC_W; storage holds IFQ_PC_W PC bits.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned PC_W  = IFQ_PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_instr,
  input  logic [PC_W-1:0]          enq_pc,
  output logic                     I_FIFO_Full,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [31:0]              deq_instr,
  output logic [PC_W-1:0]          deq_pc,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ifq_entry_t       mem [DEPTH];
  ifq_entry_t       wr_entry;
  ifq_entry_t       head_entry;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic             full_q;
  logic             nonempty_q;

  logic             bypass_c;
  logic             do_enq_c;
  logic             do_deq_c;

  // Head/tail pointers; flush returns both to slot 0.
  ifq_ptr #(.DEPTH(DEPTH)) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .inc (do_deq_c),
    .clr (flush),
    .ptr (head)
  );

  ifq_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .inc (do_enq_c),
    .clr (flush),
    .ptr (tail)
  );

  // Bypass qualifier: empty queue seeing a live, unflushed enqueue.
`ifdef IFETCH_QUEUE_BYPASS_EN
  assign bypass_c = ~nonempty_q & enq_valid & ~flush;
`else
  assign bypass_c = 1'b0;
`endif

  // Handshake decode and next occupancy. A bypassed instruction that decode
  // takes in the same cycle is never written, so it does not count.
  always_comb begin
    do_deq_c = nonempty_q & deq_ready & ~flush;
    do_enq_c = enq_valid & ~full_q & ~flush & ~(bypass_c & deq_ready);
    count_n  = count_q;
    if (flush) begin
      count_n = '0;
    end else begin
      count_n = count_q + CNT_W'(do_enq_c) - CNT_W'(do_deq_c);
    end
  end

  // Occupancy and its registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      full_q     <= 1'b0;
      nonempty_q <= 1'b0;
    end else begin
      count_q    <= count_n;
      full_q     <= (count_n == FULL_CNT);
      nonempty_q <= (count_n != '0);
    end
  end

  assign wr_entry.instr = enq_instr;
  assign wr_entry.pc    = IFQ_PC_W'(enq_pc);

  // Entry storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_enq_c) begin
      mem[tail] <= wr_entry;
    end
  end

  assign head_entry = mem[head];

  // Head presentation, optionally overridden by the bypassed enqueue.
  always_comb begin
    deq_valid = nonempty_q | bypass_c;
    deq_instr = head_entry.instr;
    deq_pc    = PC_W'(head_entry.pc);
`ifdef IFETCH_QUEUE_BYPASS_EN
    if (bypass_c) begin
      deq_instr = enq_instr;
      deq_pc    = enq_pc;
    end
`endif
  end

  assign I_FIFO_Full = full_q;
  assign count       = count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue (DEPTH=8, PC_W=32).
// Honours IFETCH_QUEUE_BYPASS_EN for the empty-queue bypass expectations.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_instr;
  logic [31:0] enq_pc;
  logic        I_FIFO_Full;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic        flush;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  ifetch_queue #(.DEPTH(8), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .enq_valid   (enq_valid),
    .enq_instr   (enq_instr),
    .enq_pc      (enq_pc),
    .I_FIFO_Full (I_FIFO_Full),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_instr   (deq_instr),
    .deq_pc      (deq_pc),
    .flush       (flush),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst       = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
  endtask

  // Enqueue one instruction with decode stalled.
  task automatic push(input logic [31:0] pc);
    enq_valid = 1'b1;
    enq_pc    = pc;
    enq_instr = instr_of(pc);
    deq_ready = 1'b0;
    tick();
    enq_valid = 1'b0;
  endtask

  // Dequeue one instruction, checking the head before the edge.
  task automatic pop(input logic [31:0] pc);
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    #1;
    chk("pop_valid", 64'(deq_valid), 64'(1'b1));
    chk("pop_pc", 64'(deq_pc), 64'(pc));
    chk("pop_instr", 64'(deq_instr), 64'(instr_of(pc)));
    tick();
    deq_ready = 1'b0;
  endtask

  initial begin
    idle();
    enq_pc    = '0;
    enq_instr = '0;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_full", 64'(I_FIFO_Full), 64'(0));
    chk("rst_valid", 64'(deq_valid), 64'(0));

    // Fill to full; first entry visible one cycle after its enqueue.
    push(32'h100);
    chk("lat_valid", 64'(deq_valid), 64'(1));
    chk("lat_pc", 64'(deq_pc), 64'h100);
    for (int i = 1; i < 8; i++) push(32'h100 + 32'(4 * i));
    chk("fill_count", 64'(count), 64'(8));
    chk("fill_full", 64'(I_FIFO_Full), 64'(1));
    push(32'h120);
    chk("drop_count", 64'(count), 64'(8));
    chk("drop_full", 64'(I_FIFO_Full), 64'(1));

    // Full with simultaneous enq+deq: no pass-through.
    enq_valid = 1'b1;
    enq_pc    = 32'h120;
    enq_instr = instr_of(32'h120);
    deq_ready = 1'b1;
    #1;
    chk("full_deq_pc", 64'(deq_pc), 64'h100);
    tick();
    idle();
    chk("full_deq_count", 64'(count), 64'(7));
    chk("full_deq_full", 64'(I_FIFO_Full), 64'(0));
    for (int i = 1; i < 8; i++) pop(32'h100 + 32'(4 * i));
    chk("drain_count", 64'(count), 64'(0));
    chk("drain_valid", 64'(deq_valid), 64'(0));

    // Streaming across pointer wrap with constant occupancy.
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(4 * i));
    chk("pre_stream_count", 64'(count), 64'(3));
    for (int i = 0; i < 20; i++) begin
      enq_valid = 1'b1;
      enq_pc    = 32'h30C + 32'(4 * i);
      enq_instr = instr_of(enq_pc);
      deq_ready = 1'b1;
      #1;
      chk("stream_pc", 64'(deq_pc), 64'(32'h300 + 32'(4 * i)));
      tick();
      chk("stream_count", 64'(count), 64'(3));
    end
    idle();
    for (int i = 20; i < 23; i++) pop(32'h300 + 32'(4 * i));
    chk("stream_empty", 64'(count), 64'(0));

    // Flush beats simultaneous enq and deq.
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(4 * i));
    chk("pre_flush_count", 64'(count), 64'(5));
    flush     = 1'b1;
    enq_valid = 1'b1;
    enq_pc    = 32'h500;
    enq_instr = instr_of(32'h500);
    deq_ready = 1'b1;
    tick();
    idle();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(deq_valid), 64'(0));
    push(32'h504);
    push(32'h508);
    chk("post_flush_count", 64'(count), 64'(2));
    pop(32'h504);
    pop(32'h508);
    chk("post_flush_empty", 64'(count), 64'(0));

    // Reset mid-stream beats a pending enqueue.
    for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i));
    rst       = 1'b1;
    enq_valid = 1'b1;
    enq_pc    = 32'h700;
    enq_instr = instr_of(32'h700);
    tick();
    idle();
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_full", 64'(I_FIFO_Full), 64'(0));
    chk("mid_rst_valid", 64'(deq_valid), 64'(0));
    push(32'h704);
    chk("post_rst_count", 64'(count), 64'(1));
    pop(32'h704);

    // Empty-queue enqueue with decode ready.
    enq_valid = 1'b1;
    enq_pc    = 32'h200;
    enq_instr = instr_of(32'h200);
    deq_ready = 1'b1;
    #1;
`ifdef IFETCH_QUEUE_BYPASS_EN
    chk("byp_valid", 64'(deq_valid), 64'(1));
    chk("byp_pc", 64'(deq_pc), 64'h200);
    chk("byp_instr", 64'(deq_instr), 64'(instr_of(32'h200)));
    tick();
    idle();
    #1;
    chk("byp_count", 64'(count), 64'(0));
    chk("byp_after_valid", 64'(deq_valid), 64'(0));
`else
    chk("nobyp_valid", 64'(deq_valid), 64'(0));
    tick();
    idle();
    #1;
    chk("nobyp_count", 64'(count), 64'(1));
    pop(32'h200);
    chk("nobyp_empty", 64'(count), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
